// File: rtl/fifo_word_packer_if.sv
// Bus bundle for fifo_word_packer: upstream show-ahead FIFO read port,
// flush request, and the packed-word output with its valid/ready handshake.
interface fifo_word_packer_if #(
    parameter int width = 8,
    parameter int ratio = 4
);
    localparam int cw = $clog2(ratio + 1);

    logic                   empty;
    logic [width-1:0]       read_data;
    logic                   pop;
    logic                   flush;
    logic                   out_valid;
    logic                   out_ready;
    logic [width*ratio-1:0] out_data;
    logic [cw-1:0]          out_count;
    logic [cw-1:0]          dbg_cnt;

    // Packer side: consumes the FIFO and drives the output slot.
    modport master (
        input  empty, read_data, flush, out_ready,
        output pop, out_valid, out_data, out_count, dbg_cnt
    );

    // Environment side: FIFO, flush requester and downstream consumer.
    modport slave (
        output empty, read_data, flush, out_ready,
        input  pop, out_valid, out_data, out_count, dbg_cnt
    );
endinterface

// File: rtl/fifo_word_packer.sv
// Packs ratio consecutive FIFO entries into one wide word, first entry in the
// LSBs; flush emits a partial word with the unused upper entries zeroed.
module fifo_word_packer #(
    parameter int width = 8,
    parameter int ratio = 4
) (
    input logic               clk,
    input logic               rst,
    fifo_word_packer_if.master bus
);
    localparam int cw = $clog2(ratio + 1);
    localparam int aw = width * (ratio - 1);
    localparam int ow = width * ratio;
    localparam logic [cw-1:0] cnt_last = cw'(ratio - 1);

    // Handshake: a word moves downstream on every clock edge where
    // out_valid & out_ready; while out_valid & ~out_ready the slot is frozen.
    // A FIFO entry is consumed on every edge where pop is high.

    logic [aw-1:0] acc_q, acc_d;
    logic [cw-1:0] cnt_q, cnt_d;
    logic          out_valid_q, out_valid_d;
    logic [ow-1:0] out_data_q, out_data_d;
    logic [cw-1:0] out_count_q, out_count_d;

    logic          slot_free;
    logic          pop;
    logic          full_load;
    logic          flush_ok;
    logic          load;
    logic [ow-1:0] word;

    always_comb begin
        slot_free = ~out_valid_q | bus.out_ready;
        pop       = ~rst & ~bus.empty & ((cnt_q != cnt_last) | slot_free);
        full_load = pop & (cnt_q == cnt_last);
        flush_ok  = bus.flush & slot_free & ((cnt_q != '0) | pop);
        load      = full_load | flush_ok;

        // Accumulator extended with a zero top entry, popped entry merged at cnt.
        word = {{width{1'b0}}, acc_q};
        for (int i = 0; i < ratio; i++) begin
            if (pop && (cnt_q == cw'(i))) begin
                word[i*width +: width] = bus.read_data;
            end
        end

        acc_d       = acc_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_count_d = out_count_q;

        if (load) begin
            out_valid_d = 1'b1;
            out_data_d  = word;
            out_count_d = cnt_q + cw'(pop);
            cnt_d       = '0;
            acc_d       = '0;
        end else begin
            if (pop) begin
                acc_d = word[aw-1:0];
                cnt_d = cnt_q + cw'(1);
            end
            if (out_valid_q & bus.out_ready) begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_count_q <= '0;
        end else begin
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_count_q <= out_count_d;
        end
    end

    assign bus.pop       = pop;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_count = out_count_q;
    assign bus.dbg_cnt   = cnt_q;
endmodule

// File: doc/fifo_word_packer.md
FIFO_WORD_PACKER -- requirements
Module: fifo_word_packer

Interface
REQ-001 The block SHALL have parameter width, default 8, meaning bit width of one FIFO entry.
REQ-002 The block SHALL have parameter ratio, default 4, meaning FIFO entries packed per output word (integer, 2..16).
REQ-003 The block SHALL use one clock and a synchronous, active-high reset, with ports named clk and rst.
REQ-004 clk  input  1  clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 empty  input  1  upstream FIFO empty flag.
REQ-007 read_data  input  width  upstream FIFO head entry, valid whenever empty==0 (show-ahead).
REQ-008 pop  output  1  upstream FIFO pop; head entry consumed on the clock edge where pop==1.
REQ-009 flush  input  1  request to emit a partially filled word.
REQ-010 out_valid  output  1  out_data/out_count hold a word.
REQ-011 out_ready  input  1  downstream accepts the word on the edge where out_valid & out_ready.
REQ-012 out_data  output  width*ratio  packed word.
REQ-013 out_count  output  $clog2(ratio+1)  number of valid entries in out_data (ratio for a full word).

Function
REQ-014 The block SHALL hold an accumulator of ratio-1 entry slots plus a fill counter cnt (0..ratio-1) and a single registered output slot (out_valid, out_data, out_count).
REQ-015 The output slot SHALL be "free" in a cycle when out_valid==0 or out_ready==1.
REQ-016 pop SHALL be combinational: pop = ~rst & ~empty & (cnt < ratio-1 | slot free).
REQ-017 A popped entry SHALL be placed at bit range [cnt*width +: width]; the first popped entry occupies the LSBs.
REQ-018 A pop with cnt < ratio-1 and no honoured flush SHALL store the entry and increment cnt; output slot unaffected.
REQ-019 A pop with cnt == ratio-1 SHALL load the output slot with accumulator plus that entry, out_count=ratio, out_valid=1, and clear cnt to 0, in the same edge.
REQ-020 Latency: last entry popped at edge N SHALL appear on out_valid/out_data after edge N (visible in cycle N+1).
REQ-021 Sustained throughput SHALL be one entry per cycle with out_ready held 1 and empty held 0; no bubbles at word boundaries.
REQ-022 The slot SHALL retain out_data/out_count/out_valid unchanged while out_valid & ~out_ready.
REQ-023 On accept (out_valid & out_ready) with no new load, out_valid SHALL go 0 at that edge.
REQ-024 flush SHALL be honoured only when slot free and (cnt>0 or pop); otherwise ignored, and the requester holds it.
REQ-025 An honoured flush SHALL load the slot with accumulated entries plus the same-cycle popped entry (if any), unused upper entries zero, out_count = cnt + pop, and clear cnt to 0.
REQ-026 flush with cnt==0 and no pop SHALL be a no-op; flush coinciding with the REQ-019 full-word case SHALL yield out_count=ratio (identical to no flush).
REQ-027 Entries SHALL never be lost, duplicated or reordered; pop SHALL never be 1 when empty==1.

Reset
REQ-028 While rst==1: pop=0; at the edge, out_valid=0, cnt=0, out_count=0, out_data=0.
REQ-029 Reset mid-operation SHALL discard accumulated and held entries; no output word derived from them after reset deasserts.

Verification (width=8, ratio=4, paired with the pow2-depth FIFO, depth 8)
REQ-030 Push 0x00,0x11..0x77, out_ready=1 -> two words 0x33221100 then 0x77665544, out_count=4, 8 pops in 8 consecutive cycles.
REQ-031 Same stimulus, out_ready=0 -> first word held stable, pop drops to 0 after 7 pops with cnt=3, FIFO retains 0x77; raise out_ready -> second word 0x77665544 follows.
REQ-032 Push 0xAA,0xBB, then flush for one cycle -> out_data=0x0000BBAA, out_count=2, cnt=0 after.
REQ-033 Push 0x10,0x20,0x30, assert flush in the cycle 0x30 is popped -> out_data=0x00302010, out_count=3.
REQ-034 Push 0x01,0x02, assert rst 2 cycles, then push 0x03..0x06 -> only word 0x06050403 emitted.
REQ-035 1000-cycle randomized push/pop/flush/out_ready against a scoreboard model -> every entry appears once, in order, with correct out_count; REQ-022 and REQ-027 asserted every cycle.
